// File: rtl/ls04_hex_inverter.sv
// rtl/ls04_hex_inverter.sv - 74LS04-style hex inverter with registered monitor and toggle flags
// Optional per-channel saturating toggle counters enabled by defining LS04_TOGGLE_CNT_EN.
module ls04_hex_inverter #(
   parameter int WIDTH = 6,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] A,
   output logic [WIDTH-1:0] Y,
   output logic [WIDTH-1:0] y_q,
   output logic [WIDTH-1:0] tog,
   input  logic [2:0]       cnt_sel,
   input  logic             cnt_clr,
   output logic [CNT_W-1:0] cnt_out
);

   localparam int SEL_W = 3;

   logic [WIDTH-1:0] r_a_prev;
   logic [WIDTH-1:0] r_y_q;
   logic [WIDTH-1:0] r_tog;

   // The combinational path never touches clk or rst so Y is valid with no clock running.
   assign Y = ~A;

   // Reset state mirrors A=0 having been sampled, so the first post-reset tog compares against zero.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_a_prev <= '0;
         r_y_q    <= '1;
         r_tog    <= '0;
      end else begin
         r_a_prev <= A;
         r_y_q    <= ~A;
         r_tog    <= A ^ r_a_prev;
      end
   end

   assign y_q = r_y_q;
   assign tog = r_tog;

`ifdef LS04_TOGGLE_CNT_EN
   logic [CNT_W-1:0] r_cnt [WIDTH];
   logic [CNT_W-1:0] w_cnt_mux;

   // Priority: rst, then cnt_clr, then a saturating increment from the registered tog.
   always_ff @(posedge clk) begin
      for (int i = 0; i < WIDTH; i++) begin
         if (rst) begin
            r_cnt[i] <= '0;
         end else if (cnt_clr) begin
            r_cnt[i] <= '0;
         end else if (r_tog[i] && (r_cnt[i] != '1)) begin
            r_cnt[i] <= r_cnt[i] + CNT_W'(1);
         end
      end
   end

   // Selects at or beyond WIDTH fall through to zero.
   always_comb begin
      w_cnt_mux = '0;
      for (int i = 0; i < WIDTH; i++) begin
         if (cnt_sel == SEL_W'(i)) begin
            w_cnt_mux = r_cnt[i];
         end
      end
   end

   assign cnt_out = w_cnt_mux;
`else
   logic w_unused_cnt;
   assign w_unused_cnt = ^{cnt_sel, cnt_clr};
   assign cnt_out      = '0;
`endif

endmodule

// File: tb/tb_ls04_hex_inverter.sv
// tb/tb_ls04_hex_inverter.sv - directed vector bench for ls04_hex_inverter
module tb_ls04_hex_inverter;

`ifdef LS04_TOGGLE_CNT_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif

   typedef struct {
      logic [5:0] a;
      logic [5:0] y;
   } vec_t;

   logic        clk;
   logic        clk_en;
   logic        rst;
   logic [5:0]  A;
   logic [2:0]  cnt_sel;
   logic        cnt_clr;
   logic [5:0]  Y, y_q, tog;
   logic [15:0] cnt_out;
   logic [5:0]  Y4, y_q4, tog4;
   logic [3:0]  cnt_out4;

   int n_vec = 0;
   int n_bad = 0;

   ls04_hex_inverter #(.WIDTH(6), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .A(A), .Y(Y), .y_q(y_q), .tog(tog),
      .cnt_sel(cnt_sel), .cnt_clr(cnt_clr), .cnt_out(cnt_out)
   );

   ls04_hex_inverter #(.WIDTH(6), .CNT_W(4)) dut4 (
      .clk(clk), .rst(rst), .A(A), .Y(Y4), .y_q(y_q4), .tog(tog4),
      .cnt_sel(cnt_sel), .cnt_clr(cnt_clr), .cnt_out(cnt_out4)
   );

   initial begin
      clk = 1'b0;
      forever begin
         #5;
         if (clk_en) clk = ~clk;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   vec_t tbl [9];

   initial begin
      tbl[0] = '{6'b000001, 6'b111110};
      tbl[1] = '{6'b000010, 6'b111101};
      tbl[2] = '{6'b000100, 6'b111011};
      tbl[3] = '{6'b001000, 6'b110111};
      tbl[4] = '{6'b010000, 6'b101111};
      tbl[5] = '{6'b100000, 6'b011111};
      tbl[6] = '{6'b000000, 6'b111111};
      tbl[7] = '{6'b111111, 6'b000000};
      tbl[8] = '{6'b101010, 6'b010101};

      clk_en  = 1'b0;
      rst     = 1'b0;
      cnt_sel = 3'd0;
      cnt_clr = 1'b0;
      A       = 6'd0;

      // Exhaustive combinational sweep with the clock stopped.
      for (int v = 0; v < 64; v++) begin
         A = 6'(v);
         #10;
         check("comb_sweep", {26'd0, Y}, {26'd0, 6'h3f - 6'(v)});
      end

      for (int k = 0; k < 9; k++) begin
         A = tbl[k].a;
         #10;
         check("comb_table", {26'd0, Y}, {26'd0, tbl[k].y});
         check("comb_table_c4", {26'd0, Y4}, {26'd0, tbl[k].y});
      end

      // Reset held two cycles with A=101010.
      A      = 6'b101010;
      rst    = 1'b1;
      clk_en = 1'b1;
      tick();
      check("rst_Y_c1", {26'd0, Y}, 32'h15);
      tick();
      check("rst_Y_c2", {26'd0, Y}, 32'h15);
      check("rst_y_q", {26'd0, y_q}, 32'h3f);
      check("rst_tog", {26'd0, tog}, 32'h0);
      for (int s = 0; s < 8; s++) begin
         cnt_sel = 3'(s);
         #1;
         check("rst_cnt_out", {16'd0, cnt_out}, 32'h0);
      end

      A   = 6'b000000;
      rst = 1'b0;
      tick();
      check("post_rst_y_q", {26'd0, y_q}, 32'h3f);
      check("post_rst_tog", {26'd0, tog}, 32'h0);

      // Registered path: 000000 -> 000101.
      A = 6'b000101;
      tick();
      check("reg_y_q", {26'd0, y_q}, 32'h3a);
      check("reg_tog", {26'd0, tog}, 32'h05);
      tick();
      check("reg_tog_drop", {26'd0, tog}, 32'h00);
      check("reg_y_q_hold", {26'd0, y_q}, 32'h3a);

      // First cycle after reset compares A against a zeroed history.
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();
      check("rst_hist_tog", {26'd0, tog}, 32'h05);
      A = 6'b000000;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();

      // Five toggles on channel 2, then idle so the counter settles.
      for (int t = 0; t < 5; t++) begin
         A[2] = ~A[2];
         tick();
         check("tog2_pulse", {26'd0, tog}, 32'h04);
      end
      tick();
      check("tog2_idle", {26'd0, tog}, 32'h00);
      tick();
      cnt_sel = 3'd2; #1;
      check("cnt_sel2", {16'd0, cnt_out}, CNT_EN ? 32'd5 : 32'd0);
      cnt_sel = 3'd3; #1;
      check("cnt_sel3", {16'd0, cnt_out}, 32'd0);
      cnt_sel = 3'd6; #1;
      check("cnt_sel6", {16'd0, cnt_out}, 32'd0);
      cnt_sel = 3'd7; #1;
      check("cnt_sel7", {16'd0, cnt_out}, 32'd0);

      // Clear coincident with a pending increment wins.
      cnt_sel = 3'd2;
      A[2] = ~A[2];
      tick();
      cnt_clr = 1'b1;
      tick();
      cnt_clr = 1'b0;
      check("clr_same_cycle", {16'd0, cnt_out}, 32'd0);
      tick();
      check("clr_after", {16'd0, cnt_out}, 32'd0);

      // Saturation: 20 toggles on channel 0.
      rst = 1'b1;
      A   = 6'b000000;
      tick();
      rst = 1'b0;
      for (int t = 0; t < 20; t++) begin
         A[0] = ~A[0];
         tick();
      end
      tick();
      tick();
      cnt_sel = 3'd0; #1;
      check("sat_cnt4", {28'd0, cnt_out4}, CNT_EN ? 32'd15 : 32'd0);
      check("sat_cnt16", {16'd0, cnt_out}, CNT_EN ? 32'd20 : 32'd0);

      // Reset outranks a simultaneous clear and leaves everything zeroed.
      rst     = 1'b1;
      cnt_clr = 1'b1;
      tick();
      rst     = 1'b0;
      cnt_clr = 1'b0;
      check("rst_over_clr", {28'd0, cnt_out4}, 32'd0);
      check("rst_over_clr_y_q", {26'd0, y_q4}, 32'h3f);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/ls04_hex_inverter.md
Name: ls04_hex_inverter

Overview:
- Six independent inverters modelled on the 74LS04, with a combinational path Y = ~A.
- A clocked monitor registers the inverted outputs and flags per-channel input transitions.
- Optional per-channel toggle counters support activity and coverage measurement.
- Used as a glue-logic leaf cell wherever bit inversion plus observability is needed.

Parameters:
- WIDTH, 6, number of inverter channels; fixed at 6 for 74LS04 semantics; all logic must be written generically in WIDTH.
- CNT_W, 16, width of each toggle counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous reset, active-high.
- A  input  WIDTH  inverter inputs; channel i is A[i].
- Y  output  WIDTH  combinational inverter outputs, Y[i] = ~A[i].
- y_q  output  WIDTH  registered copy of ~A.
- tog  output  WIDTH  per-channel one-cycle pulse when A[i] differs from its previously sampled value.
- cnt_sel  input  3  selects which channel's counter drives cnt_out.
- cnt_clr  input  1  synchronous clear of all toggle counters.
- cnt_out  output  CNT_W  toggle count of the channel selected by cnt_sel.

Behaviour:
- Y:
  - Purely combinational, zero latency, bitwise ~A.
  - Independent of clk and rst; valid during reset and with no clock running.
  - Each channel depends only on its own input; no cross-channel coupling.
  - Any A value (all 64 codes) produces exactly ~A once settled.
- Sampling on each rising clk edge:
  - a_prev <= A, y_q <= ~A.
  - tog is registered: tog[i] <= A[i] ^ a_prev[i].
  - Latency from an A change to y_q and tog is 1 cycle. tog is high for exactly one cycle per change.
- Reset (rst=1 at a clock edge):
  - a_prev <= 0, y_q <= all ones (consistent with A=0), tog <= 0, all counters <= 0.
  - Reset overrides sampling and counting in the same cycle.
  - Reset mid-operation discards the pending transition history.
  - On the first cycle after reset, tog reflects A against a_prev = 0.
- Counters (when LS04_TOGGLE_CNT_EN is defined):
  - One CNT_W-bit counter per channel; increments when that channel's registered tog is 1.
  - Saturates at all ones with no wrap.
  - cnt_clr=1 zeroes all counters and takes priority over a simultaneous increment.
  - rst takes priority over cnt_clr.
- cnt_out:
  - Combinational mux of the selected counter.
  - cnt_sel >= WIDTH (values 6 and 7) drives cnt_out = 0.
- No handshake. Every output is defined at all times after the first reset; no X on registered outputs after reset.

Optional Feature:
- Macro LS04_TOGGLE_CNT_EN.
- Defined: per-channel saturating toggle counters, cnt_clr and the cnt_out mux exist as described.
- Undefined: no counter storage is synthesised, cnt_out is tied to 0, and cnt_sel and cnt_clr are ignored. Ports remain present so the interface is identical.
- Y, y_q and tog behave identically either way.

Test Plan:
- Exhaustive combinational check: step A through 0..63, hold 10 time units each, with no clock. Y must equal ~A on every step (e.g. A=000000 -> Y=111111, A=111111 -> Y=000000, A=101010 -> Y=010101).
- Walking one: A = 1<<i for i = 0..5. Y[i] must be 0 and all other Y bits 1, i.e. Y == ~A.
- Reset: assert rst for 2 cycles with A=101010. Y must be 010101 throughout; after reset y_q=111111, tog=0, cnt_out=0 for every cnt_sel.
- Registered path: A goes 000000 -> 000101. On the next cycle y_q=111010 and tog=000101 for one cycle; the following cycle tog=000000.
- Counters (macro defined): toggle A[2] five times with reset released -> cnt_sel=2 gives cnt_out=5, cnt_sel=3 gives 0, cnt_sel=7 gives 0. Assert cnt_clr in the same cycle as a toggle -> cnt_out=0.
- Saturation (CNT_W=4, macro defined): toggle A[0] 20 times -> cnt_out=15 with no wrap. With the macro undefined, the same stimulus -> cnt_out=0.
